rom_load_ctrl: RTL
==================

Name: rom_load_ctrl

Overview:
- Sequences the MiSTer ROM download stream (hps_io ioctl_*) into the williams2 core's ROM regions.
- Decodes each downloaded byte into one of four target regions (CPU program, sound, graphics, decoder PROM) and issues a write/ack handshake per byte.
- Back-pressures hps_io with ioctl_wait while a write is outstanding.
- Owns the core reset: the core is held in reset until a complete load finishes, and again on user/OSD reset requests.

Parameters:
- ROM_INDEX, 0, ioctl_index value accepted as ROM data; all other indices are ignored.
- AW, 25, ioctl_addr width.
- BASE_SND, 25'h18000, first byte of the sound region; the CPU region runs from 0 to BASE_SND-1.
- BASE_GFX, 25'h20000, first byte of the graphics region.
- BASE_PROM, 25'h30000, first byte of the decoder PROM region.
- TOTAL, 25'h30200, first out-of-range byte.
- ACK_TIMEOUT, 15, maximum cycles to wait for rom_wr_ack.
- HOLD_CYCLES, 255, core reset hold time after a load completes or after a reset request.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  AW  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- rom_wr_sel  out  4  one-hot target: [0] cpu, [1] snd, [2] gfx, [3] prom.
- rom_wr_addr  out  17  offset within the region (ioctl_addr minus region base).
- rom_wr_data  out  8  byte to write.
- rom_wr_ack  in  1  target accepted the write.
- core_reset_req  in  1  synchronous, active-high user/OSD reset.
- core_reset_n  out  1  reset to williams2 (low = held).
- loaded  out  1  a complete load has finished.
- overflow  out  1  sticky: a byte arrived with address >= TOTAL.
- ack_err  out  1  sticky: an ack timeout occurred.

Behaviour:
- Reset values: all outputs registered. core_reset_n=0, ioctl_wait=0, rom_wr_sel=0, rom_wr_addr=0, rom_wr_data=0, loaded=0, overflow=0, ack_err=0. State=IDLE.
- States: IDLE, ACTIVE, WRITE, DRAIN, HOLD, RUN.
- IDLE: core_reset_n=0.
  - ioctl_download=1 with ioctl_index==ROM_INDEX -> ACTIVE; overflow and ack_err are cleared on entry.
- ACTIVE, on a sampled ioctl_wr:
  - Latch ioctl_addr and ioctl_dout; decode to the highest base <= addr.
  - In range: on the next edge, ioctl_wait=1, rom_wr_sel=one-hot, rom_wr_addr=addr-base (low 17 bits), rom_wr_data=byte -> WRITE.
  - addr >= TOTAL: byte discarded, overflow=1, ioctl_wait stays 0, remain in ACTIVE.
- ACTIVE, when ioctl_download falls -> HOLD.
- WRITE: outputs held stable until rom_wr_ack is sampled high.
  - The edge after ack: rom_wr_sel=0, ioctl_wait=0 -> ACTIVE, or -> DRAIN if download has already fallen.
  - Minimum ioctl_wr-to-wait-release: 2 cycles with an immediate ack.
  - The timeout counter starts at 0 on entry. If ACK_TIMEOUT cycles pass without ack: ack_err=1, the write is abandoned, and the exit is the same as for an ack.
- DRAIN: one cycle, then -> HOLD. Back-to-back ioctl_wr is impossible while ioctl_wait=1; a wr sampled while in WRITE is ignored.
- HOLD: core_reset_n=0; a counter runs 0..HOLD_CYCLES.
  - At terminal count -> RUN, core_reset_n=1, loaded=1.
  - core_reset_req during HOLD restarts the counter.
- RUN: core_reset_n=1.
  - core_reset_req -> HOLD with core_reset_n=0 on the next edge.
- Any state: download rising with a matching index -> ACTIVE.
  - Takes priority over core_reset_req.
  - core_reset_n=0 and loaded=0 on the next edge.
  - Abandons any in-progress write: rom_wr_sel=0, ioctl_wait=0.
- ioctl_download with a non-matching index is ignored in every state.
- Asynchronous reset mid-write: all outputs return to reset values immediately; the write is lost and the host must re-download.

Decomposition:
- Package williams2_load_pkg:
  - state enum.
  - region-select typedef with one-hot constants SEL_CPU/SEL_SND/SEL_GFX/SEL_PROM.
  - default base/size constants.
- One sub-module, rom_region_decode: combinational address -> {sel, offset, in_range}, so the decode is reusable by an upload path.
- Counters (timeout, hold) stay inline.

Test Plan:
- Reset, no download -> core_reset_n=0, loaded=0 indefinitely.
- Download index 0, bytes at 0x00000=0xA5 and 0x18003=0x3C, ack 1 cycle after sel -> sel=0001 with offset 0x0000, then sel=0010 with offset 0x0003; ioctl_wait high exactly 2 cycles per byte.
- Byte at 0x30200 -> overflow=1, no sel pulse, ioctl_wait stays 0; byte at 0x301FF -> sel=1000, offset 0x1FF.
- rom_wr_ack held low -> ack_err=1 after 15 cycles; sel and wait drop; the next byte proceeds normally.
- Download falls while in WRITE, ack arrives 3 cycles later -> DRAIN then HOLD; core_reset_n rises 256 cycles later; loaded=1.
- In RUN, pulse core_reset_req -> core_reset_n=0 for 256 cycles. Index-1 download -> no effect. Index-0 download mid-HOLD -> ACTIVE; loaded=0; overflow cleared.

Source files
------------

// File: rtl/williams2_load_pkg.sv
// Shared types and defaults for the williams2 ROM load path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package williams2_load_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_RUN    = 3'd5
  } state_t;

  // One-hot ROM region select: [0] cpu, [1] snd, [2] gfx, [3] prom.
  typedef logic [3:0] sel_t;

  localparam sel_t SEL_NONE = 4'b0000;
  localparam sel_t SEL_CPU  = 4'b0001;
  localparam sel_t SEL_SND  = 4'b0010;
  localparam sel_t SEL_GFX  = 4'b0100;
  localparam sel_t SEL_PROM = 4'b1000;

  // Download address width and per-region write offset width.
  localparam int unsigned DEF_AW   = 25;
  localparam int unsigned OFFSET_W = 17;

  // Default memory map of the concatenated ROM image.
  localparam logic [DEF_AW-1:0] DEF_BASE_SND  = 25'h18000;
  localparam logic [DEF_AW-1:0] DEF_BASE_GFX  = 25'h20000;
  localparam logic [DEF_AW-1:0] DEF_BASE_PROM = 25'h30000;
  localparam logic [DEF_AW-1:0] DEF_TOTAL     = 25'h30200;

endpackage

// File: rtl/rom_region_decode.sv
// Maps a flat ROM image byte address to a one-hot region select and region offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
module rom_region_decode
  import williams2_load_pkg::*;
#(
  parameter int unsigned     AW        = DEF_AW,
  parameter logic [AW-1:0]   BASE_SND  = AW'(DEF_BASE_SND),
  parameter logic [AW-1:0]   BASE_GFX  = AW'(DEF_BASE_GFX),
  parameter logic [AW-1:0]   BASE_PROM = AW'(DEF_BASE_PROM),
  parameter logic [AW-1:0]   TOTAL     = AW'(DEF_TOTAL)
) (
  input  logic [AW-1:0]       addr,
  output sel_t                sel,
  output logic [OFFSET_W-1:0] offset,
  output logic                in_range
);

  logic [AW-1:0] base;

  // Pick the highest region base not above the address; beyond TOTAL nothing matches.
  always_comb begin
    sel      = SEL_NONE;
    base     = '0;
    in_range = 1'b0;
    if (addr >= TOTAL) begin
      sel      = SEL_NONE;
      base     = '0;
      in_range = 1'b0;
    end else if (addr >= BASE_PROM) begin
      sel      = SEL_PROM;
      base     = BASE_PROM;
      in_range = 1'b1;
    end else if (addr >= BASE_GFX) begin
      sel      = SEL_GFX;
      base     = BASE_GFX;
      in_range = 1'b1;
    end else if (addr >= BASE_SND) begin
      sel      = SEL_SND;
      base     = BASE_SND;
      in_range = 1'b1;
    end else begin
      sel      = SEL_CPU;
      base     = '0;
      in_range = 1'b1;
    end
    offset = OFFSET_W'(addr - base);
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Steers the hps_io ROM download into williams2 ROM regions and owns the core reset.
// Latency: outputs update on the edge sampling ioctl_wr; wait drops on the edge sampling ack (2 cycles min).
// Backpressure: ioctl_wait stays high while a region write is outstanding (ack or timeout releases it).
module rom_load_ctrl
  import williams2_load_pkg::*;
#(
  parameter logic [7:0]      ROM_INDEX   = 8'd0,
  parameter int unsigned     AW          = DEF_AW,
  parameter logic [AW-1:0]   BASE_SND    = AW'(DEF_BASE_SND),
  parameter logic [AW-1:0]   BASE_GFX    = AW'(DEF_BASE_GFX),
  parameter logic [AW-1:0]   BASE_PROM   = AW'(DEF_BASE_PROM),
  parameter logic [AW-1:0]   TOTAL       = AW'(DEF_TOTAL),
  parameter int unsigned     ACK_TIMEOUT = 15,
  parameter int unsigned     HOLD_CYCLES = 255
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  output logic [3:0]          rom_wr_sel,
  output logic [OFFSET_W-1:0] rom_wr_addr,
  output logic [7:0]          rom_wr_data,
  input  logic                rom_wr_ack,
  input  logic                core_reset_req,
  output logic                core_reset_n,
  output logic                loaded,
  output logic                overflow,
  output logic                ack_err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

  state_t                state;
  logic                  dl_q;
  logic [TW-1:0]         to_cnt;
  logic [HW-1:0]         hold_cnt;

  sel_t                  dec_sel;
  logic [OFFSET_W-1:0]   dec_offset;
  logic                  dec_in_range;

  logic                  dl_match;
  logic                  dl_start;

  // Only downloads tagged with our index count; a fresh one restarts everything.
  assign dl_match = ioctl_download && (ioctl_index == ROM_INDEX);
  assign dl_start = dl_match && !dl_q;

  rom_region_decode #(
    .AW        (AW),
    .BASE_SND  (BASE_SND),
    .BASE_GFX  (BASE_GFX),
    .BASE_PROM (BASE_PROM),
    .TOTAL     (TOTAL)
  ) u_decode (
    .addr     (ioctl_addr),
    .sel      (dec_sel),
    .offset   (dec_offset),
    .in_range (dec_in_range)
  );

  // Load sequencer: byte handshake, ack timeout, core reset hold and run.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      dl_q         <= 1'b0;
      to_cnt       <= '0;
      hold_cnt     <= '0;
      ioctl_wait   <= 1'b0;
      rom_wr_sel   <= SEL_NONE;
      rom_wr_addr  <= '0;
      rom_wr_data  <= '0;
      core_reset_n <= 1'b0;
      loaded       <= 1'b0;
      overflow     <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_start) begin
        // New download wins over everything, including a pending reset request.
        state        <= ST_ACTIVE;
        core_reset_n <= 1'b0;
        loaded       <= 1'b0;
        ioctl_wait   <= 1'b0;
        rom_wr_sel   <= SEL_NONE;
        overflow     <= 1'b0;
        ack_err      <= 1'b0;
        to_cnt       <= '0;
        hold_cnt     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            core_reset_n <= 1'b0;
            if (dl_match) begin
              state    <= ST_ACTIVE;
              overflow <= 1'b0;
              ack_err  <= 1'b0;
            end
          end

          ST_ACTIVE: begin
            core_reset_n <= 1'b0;
            if (!ioctl_download) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end else if (ioctl_wr) begin
              if (dec_in_range) begin
                ioctl_wait  <= 1'b1;
                rom_wr_sel  <= dec_sel;
                rom_wr_addr <= dec_offset;
                rom_wr_data <= ioctl_dout;
                to_cnt      <= '0;
                state       <= ST_WRITE;
              end else begin
                // Past the end of the image: drop the byte, remember it happened.
                overflow <= 1'b1;
              end
            end
          end

          ST_WRITE: begin
            // Outputs hold until ack; a timeout exits the same way but flags the loss.
            if (rom_wr_ack || (to_cnt == TO_LAST)) begin
              if (!rom_wr_ack) begin
                ack_err <= 1'b1;
              end
              rom_wr_sel <= SEL_NONE;
              ioctl_wait <= 1'b0;
              state      <= ioctl_download ? ST_ACTIVE : ST_DRAIN;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end

          ST_DRAIN: begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end

          ST_HOLD: begin
            core_reset_n <= 1'b0;
            if (core_reset_req) begin
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              state        <= ST_RUN;
              core_reset_n <= 1'b1;
              loaded       <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end

          ST_RUN: begin
            if (core_reset_req) begin
              state        <= ST_HOLD;
              core_reset_n <= 1'b0;
              hold_cnt     <= '0;
            end else begin
              core_reset_n <= 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
